err_collector: RTL and testbench

//  Parametrised CPU-inner error collector; successor to the single sticky error flag.

---
 rtl/err_pkg.sv | 29 ++
 rtl/err_sat_cnt.sv | 35 +++
 rtl/err_collector.sv | 138 +++++++++++++
 tb/tb_err_collector.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/err_pkg.sv
// Shared types and constants for the CPU-inner error collector.
package err_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLatched = 2'd1,
        StClear   = 2'd2
    } err_state_e;

    localparam int unsigned NUM_SRC_DEFAULT = 9;

    localparam int unsigned SRC_ICACHE = 0;
    localparam int unsigned SRC_DCACHE = 1;
    localparam int unsigned SRC_IF     = 2;
    localparam int unsigned SRC_ID     = 3;
    localparam int unsigned SRC_LAUNCH = 4;
    localparam int unsigned SRC_EX     = 5;
    localparam int unsigned SRC_MM     = 6;
    localparam int unsigned SRC_MEM    = 7;
    localparam int unsigned SRC_WB     = 8;

    // Source-index width, never narrower than one bit.
    function automatic int unsigned src_id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned SRC_ID_W = src_id_w(NUM_SRC_DEFAULT);

endpackage

// File: rtl/err_sat_cnt.sv
// Per-source saturating hit counter; a clear and an increment in the same
// cycle leave the counter at one.
module err_sat_cnt
    import err_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d, base;

    always_comb begin
        base  = clr ? '0 : cnt_q;
        cnt_d = base;
        if (inc && (base != {CNT_W{1'b1}})) begin
            cnt_d = base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/err_collector.sv
// CPU-inner error collector: sticky bits, saturating counters and first-error capture.
// Optional macro ERR_MASK_EN adds the err_mask_i source-enable port.
module err_collector
    import err_pkg::*;
#(
    parameter int unsigned NUM_SRC = 9,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TS_W    = 32,
    localparam int unsigned ID_W   = src_id_w(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC-1:0]       err_vec_i,
    input  logic                     clr_req_i,
    output logic                     clr_ack_o,
    output logic [NUM_SRC-1:0]       sticky_o,
    output logic                     any_err_o,
    output logic                     first_vld_o,
    output logic [ID_W-1:0]          first_src_o,
    output logic [TS_W-1:0]          first_ts_o,
`ifdef ERR_MASK_EN
    output logic [NUM_SRC*CNT_W-1:0] err_cnt_o,
    input  logic [NUM_SRC-1:0]       err_mask_i
`else
    output logic [NUM_SRC*CNT_W-1:0] err_cnt_o
`endif
);

    err_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] eff;
    logic [NUM_SRC-1:0] sticky_q, sticky_d;
    logic               first_vld_q, first_vld_d;
    logic [ID_W-1:0]    first_src_q, first_src_d;
    logic [TS_W-1:0]    first_ts_q, first_ts_d;
    logic [TS_W-1:0]    ts_q;
    logic [ID_W-1:0]    low_idx;
    logic               capture;
    logic               cnt_clr;

`ifdef ERR_MASK_EN
    assign eff = err_vec_i & err_mask_i;
`else
    assign eff = err_vec_i;
`endif

    // Lowest set index wins among simultaneous errors.
    always_comb begin
        low_idx = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (eff[k]) begin
                low_idx = ID_W'(k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sticky_d    = sticky_q | eff;
        first_vld_d = first_vld_q;
        first_src_d = first_src_q;
        first_ts_d  = first_ts_q;
        capture     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clr_req_i) begin
                    state_d = StClear;
                end else if (|eff) begin
                    state_d = StLatched;
                    capture = 1'b1;
                end
            end
            StLatched: begin
                if (clr_req_i) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                // Zero first, then apply what arrived during the clear cycle.
                sticky_d    = eff;
                first_vld_d = 1'b0;
                first_src_d = '0;
                first_ts_d  = '0;
                if (|eff) begin
                    state_d = StLatched;
                    capture = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (capture) begin
            first_vld_d = 1'b1;
            first_src_d = low_idx;
            first_ts_d  = ts_q;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= StIdle;
            sticky_q    <= '0;
            first_vld_q <= 1'b0;
            first_src_q <= '0;
            first_ts_q  <= '0;
            ts_q        <= '0;
        end else begin
            state_q     <= state_d;
            sticky_q    <= sticky_d;
            first_vld_q <= first_vld_d;
            first_src_q <= first_src_d;
            first_ts_q  <= first_ts_d;
            ts_q        <= ts_q + TS_W'(1);
        end
    end

    assign cnt_clr = (state_q == StClear);

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_cnt
        err_sat_cnt #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk  (clk),
            .rst_n(rst_n),
            .inc  (eff[k]),
            .clr  (cnt_clr),
            .cnt  (err_cnt_o[k*CNT_W +: CNT_W])
        );
    end

    assign clr_ack_o   = cnt_clr;
    assign sticky_o    = sticky_q;
    assign any_err_o   = |sticky_q;
    assign first_vld_o = first_vld_q;
    assign first_src_o = first_src_q;
    assign first_ts_o  = first_ts_q;

endmodule

// File: tb/tb_err_collector.sv
// Scoreboard bench for err_collector: stimulus queues expectations per cycle, a monitor checks them.
module tb_err_collector;

    localparam int unsigned NUM_SRC = 9;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TS_W    = 32;

    localparam int SEL_STICKY = 0;
    localparam int SEL_ANY    = 1;
    localparam int SEL_VLD    = 2;
    localparam int SEL_SRC    = 3;
    localparam int SEL_TS     = 4;
    localparam int SEL_CNT    = 5;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_SRC-1:0]       err_vec;
    logic                     clr_req;
    logic                     clr_ack;
    logic [NUM_SRC-1:0]       sticky;
    logic                     any_err;
    logic                     first_vld;
    logic [3:0]               first_src;
    logic [TS_W-1:0]          first_ts;
    logic [NUM_SRC*CNT_W-1:0] err_cnt;
    logic [NUM_SRC-1:0]       err_mask;

    err_collector #(
        .NUM_SRC(NUM_SRC),
        .CNT_W  (CNT_W),
        .TS_W   (TS_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .err_vec_i  (err_vec),
        .clr_req_i  (clr_req),
        .clr_ack_o  (clr_ack),
        .sticky_o   (sticky),
        .any_err_o  (any_err),
        .first_vld_o(first_vld),
        .first_src_o(first_src),
        .first_ts_o (first_ts),
`ifdef ERR_MASK_EN
        .err_cnt_o  (err_cnt),
        .err_mask_i (err_mask)
`else
        .err_cnt_o  (err_cnt)
`endif
    );

    typedef struct {
        int unsigned cyc;
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned ack_q[$];
    int unsigned cyc;
    int          n_checks = 0;
    int          n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bench cycle index: equals the cycle's timestamp once reset is released.
    always @(posedge clk or posedge rst_n) begin
        if (rst_n) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            SEL_STICKY: return 32'(sticky);
            SEL_ANY:    return 32'(any_err);
            SEL_VLD:    return 32'(first_vld);
            SEL_SRC:    return 32'(first_src);
            SEL_TS:     return first_ts;
            default:    return 32'(err_cnt[(sel-SEL_CNT)*CNT_W +: CNT_W]);
        endcase
    endfunction

    task automatic expect_at(input int unsigned c, input string name, input int sel,
                             input logic [31:0] val);
        exp_t e;
        e.cyc  = c;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic goto(input int unsigned c);
        do @(negedge clk); while (cyc < c);
    endtask

    exp_t        mon_e;
    logic [31:0] mon_act;
    int unsigned mon_ack;

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            if (mon_e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: check for cycle %0d missed, now at cycle %0d",
                         mon_e.name, mon_e.cyc, cyc);
            end else begin
                mon_act = actual(mon_e.sel);
                if (mon_act !== mon_e.val) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got %0h expected %0h",
                             mon_e.name, cyc, mon_act, mon_e.val);
                end
            end
        end
        while (ack_q.size() > 0 && ack_q[0] < cyc) begin
            mon_ack = ack_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL clr_ack: no ack at cycle %0d, got 0 expected 1", mon_ack);
        end
        if (clr_ack === 1'b1) begin
            n_checks++;
            if (ack_q.size() > 0 && ack_q[0] == cyc) begin
                void'(ack_q.pop_front());
            end else begin
                n_fail++;
                $display("FAIL clr_ack: unexpected ack at cycle %0d, got 1 expected 0", cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        err_vec  = '0;
        clr_req  = 1'b0;
        err_mask = '1;
        #1 rst_n = 1'b1;
        expect_at(0, "rst_sticky", SEL_STICKY, 32'h0);
        expect_at(0, "rst_vld",    SEL_VLD,    32'h0);
        expect_at(0, "rst_cnt0",   SEL_CNT+0,  32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;

        // 1) idle for 20 cycles
        expect_at(20, "idle_sticky", SEL_STICKY, 32'h0);
        expect_at(20, "idle_any",    SEL_ANY,    32'h0);
        expect_at(20, "idle_vld",    SEL_VLD,    32'h0);
        expect_at(20, "idle_src",    SEL_SRC,    32'h0);
        expect_at(20, "idle_ts",     SEL_TS,     32'h0);
        expect_at(20, "idle_cnt4",   SEL_CNT+4,  32'h0);
        goto(21);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;

        // 2) single error on launch at ts=5
        expect_at(5, "t2_pre_sticky", SEL_STICKY, 32'h0);
        expect_at(6, "t2_sticky",     SEL_STICKY, 32'h010);
        expect_at(6, "t2_any",        SEL_ANY,    32'h1);
        expect_at(6, "t2_vld",        SEL_VLD,    32'h1);
        expect_at(6, "t2_src",        SEL_SRC,    32'd4);
        expect_at(6, "t2_ts",         SEL_TS,     32'd5);
        expect_at(6, "t2_cnt4",       SEL_CNT+4,  32'd1);
        goto(5);  err_vec = 9'h010;
        goto(6);  err_vec = '0;

        // 5) clear from LATCHED with no new errors
        expect_at(8,  "t5_cnt4_pre", SEL_CNT+4,  32'd1);
        expect_at(10, "t5_sticky",   SEL_STICKY, 32'h0);
        expect_at(10, "t5_any",      SEL_ANY,    32'h0);
        expect_at(10, "t5_vld",      SEL_VLD,    32'h0);
        expect_at(10, "t5_src",      SEL_SRC,    32'h0);
        expect_at(10, "t5_ts",       SEL_TS,     32'h0);
        expect_at(10, "t5_cnt4",     SEL_CNT+4,  32'h0);
        ack_q.push_back(9);
        goto(8);  clr_req = 1'b1;
        goto(9);  clr_req = 1'b0;

        // 3) simultaneous errors on ex and mem; later icache error does not recapture
        expect_at(13, "t3_src",    SEL_SRC,    32'd5);
        expect_at(13, "t3_ts",     SEL_TS,     32'd12);
        expect_at(13, "t3_sticky", SEL_STICKY, 32'h0A0);
        expect_at(13, "t3_cnt5",   SEL_CNT+5,  32'd1);
        expect_at(13, "t3_cnt7",   SEL_CNT+7,  32'd1);
        expect_at(13, "t3_cnt0",   SEL_CNT+0,  32'd0);
        expect_at(16, "t3_src2",   SEL_SRC,    32'd5);
        expect_at(16, "t3_ts2",    SEL_TS,     32'd12);
        expect_at(16, "t3_sticky2", SEL_STICKY, 32'h0A1);
        expect_at(16, "t3_cnt0b",  SEL_CNT+0,  32'd1);
        goto(12); err_vec = 9'h0A0;
        goto(13); err_vec = '0;
        goto(15); err_vec = 9'h001;
        goto(16); err_vec = '0;

        // 4) hold bit 2 for 300 cycles: saturate at 255
        expect_at(274, "t4_cnt2_254", SEL_CNT+2,  32'd254);
        expect_at(275, "t4_cnt2_255", SEL_CNT+2,  32'd255);
        expect_at(321, "t4_cnt2_hold", SEL_CNT+2, 32'd255);
        expect_at(321, "t4_sticky",   SEL_STICKY, 32'h0A5);
        expect_at(321, "t4_src",      SEL_SRC,    32'd5);
        goto(20);  err_vec = 9'h004;
        goto(320); err_vec = '0;

        // 6) error arriving during the CLEAR cycle is applied after zeroing
        ack_q.push_back(331);
        expect_at(332, "t6_sticky", SEL_STICKY, 32'h001);
        expect_at(332, "t6_any",    SEL_ANY,    32'h1);
        expect_at(332, "t6_vld",    SEL_VLD,    32'h1);
        expect_at(332, "t6_src",    SEL_SRC,    32'd0);
        expect_at(332, "t6_ts",     SEL_TS,     32'd331);
        expect_at(332, "t6_cnt0",   SEL_CNT+0,  32'd1);
        expect_at(332, "t6_cnt2",   SEL_CNT+2,  32'd0);
        expect_at(335, "t6_src_frozen", SEL_SRC, 32'd0);
        expect_at(335, "t6_sticky2", SEL_STICKY, 32'h003);
        goto(330); clr_req = 1'b1;
        goto(331); clr_req = 1'b0; err_vec = 9'h001;
        goto(332); err_vec = '0;
        goto(334); err_vec = 9'h002;
        goto(335); err_vec = '0;

        // clear back to IDLE, then a clear request beats a capture in IDLE
        ack_q.push_back(341);
        ack_q.push_back(346);
        expect_at(342, "idle_again_vld", SEL_VLD,    32'h0);
        expect_at(346, "win_sticky",     SEL_STICKY, 32'h100);
        expect_at(346, "win_vld",        SEL_VLD,    32'h0);
        expect_at(346, "win_cnt8",       SEL_CNT+8,  32'd1);
        expect_at(347, "win_sticky2",    SEL_STICKY, 32'h0);
        expect_at(347, "win_cnt8b",      SEL_CNT+8,  32'd0);
        expect_at(347, "win_vld2",       SEL_VLD,    32'h0);
        goto(340); clr_req = 1'b1;
        goto(341); clr_req = 1'b0;
        goto(345); clr_req = 1'b1; err_vec = 9'h100;
        goto(346); clr_req = 1'b0; err_vec = '0;

        // held request after ack triggers a second clear
        ack_q.push_back(351);
        ack_q.push_back(353);
        expect_at(354, "held_sticky", SEL_STICKY, 32'h0);
        goto(350); clr_req = 1'b1;
        goto(353); clr_req = 1'b0;

`ifdef ERR_MASK_EN
        // 7) masked sources are ignored; dropping a mask bit keeps state
        expect_at(361, "t7_sticky", SEL_STICKY, 32'h002);
        expect_at(361, "t7_src",    SEL_SRC,    32'd1);
        expect_at(361, "t7_ts",     SEL_TS,     32'd360);
        expect_at(361, "t7_cnt0",   SEL_CNT+0,  32'd0);
        expect_at(361, "t7_cnt1",   SEL_CNT+1,  32'd1);
        expect_at(362, "t7_sticky2", SEL_STICKY, 32'h002);
        expect_at(362, "t7_cnt1b",  SEL_CNT+1,  32'd1);
        goto(360); err_mask = 9'h1FE; err_vec = 9'h003;
        goto(361); err_mask = 9'h1FD; err_vec = 9'h002;
        goto(362); err_mask = '1;     err_vec = '0;
`endif

        goto(370);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        n_checks++;
        if (ack_q.size() != 0) begin
            n_fail++;
            $display("FAIL ack_drain: got %0d pending acks expected 0", ack_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
